// File: rtl/sp1_hmem_arb.sv
// Two-requester heap access arbiter with r1 lock for atomic GC sequences.
// Optional round-robin arbitration in OPEN when SP1_HMEM_ARB_RR_EN is defined.
`ifndef SP1_WORD_WIDTH
`define SP1_WORD_WIDTH 32
`endif

module sp1_hmem_arb #(
  parameter int DW = `SP1_WORD_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_type,
  input  logic          r0_sz,
  input  logic [DW-1:0] r0_adrs,
  input  logic [DW-1:0] r0_wr_dt0,
  input  logic [DW-1:0] r0_wr_dt1,
  output logic          r0_gnt,
  output logic          r0_rd_vld,
  input  logic          r1_req,
  input  logic          r1_type,
  input  logic          r1_sz,
  input  logic [DW-1:0] r1_adrs,
  input  logic [DW-1:0] r1_wr_dt0,
  input  logic [DW-1:0] r1_wr_dt1,
  input  logic          r1_lock,
  output logic          r1_gnt,
  output logic          r1_rd_vld,
  output logic [DW-1:0] rd_dt0,
  output logic [DW-1:0] rd_dt1,
  output logic          locked,
  output logic          h5_hmem_acs_en,
  output logic          h5_hmem_acs_type,
  output logic          h5_hmem_acs_sz,
  output logic [DW-1:0] h5_hmem_acs_adrs,
  output logic [DW-1:0] h5_hmem_wr_dt0,
  output logic [DW-1:0] h5_hmem_wr_dt1,
  input  logic [DW-1:0] h6_hmem_rd_dt0,
  input  logic [DW-1:0] h6_hmem_rd_dt1
);

  // state | meaning
  // OPEN  | both requesters may be granted
  // LOCK1 | heap reserved for r1; r0 blocked
  typedef enum logic {OPEN = 1'b0, LOCK1 = 1'b1} state_t;

  state_t state, state_nxt;
  logic   gnt0, gnt1;
  logic   p1_vld, p1_org, p2_vld, p2_org;

`ifdef SP1_HMEM_ARB_RR_EN
  logic last_r1;

  always_ff @(posedge clk) begin
    if (rst)       last_r1 <= 1'b1;
    else if (gnt0) last_r1 <= 1'b0;
    else if (gnt1) last_r1 <= 1'b1;
  end
`endif

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    if (!rst) begin
      if (state == LOCK1) begin
        gnt1 = r1_req;
      end else if (r0_req && r1_req) begin
`ifdef SP1_HMEM_ARB_RR_EN
        gnt0 = last_r1;
        gnt1 = !last_r1;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = r0_req;
        gnt1 = r1_req;
      end
      if (gnt1) state_nxt = r1_lock ? LOCK1 : OPEN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= OPEN;
    else     state <= state_nxt;
  end

  // request stage: fields move only on a grant so the heap sees stable data
  always_ff @(posedge clk) begin
    if (rst) begin
      h5_hmem_acs_en   <= 1'b0;
      h5_hmem_acs_type <= 1'b0;
      h5_hmem_acs_sz   <= 1'b0;
      h5_hmem_acs_adrs <= '0;
      h5_hmem_wr_dt0   <= '0;
      h5_hmem_wr_dt1   <= '0;
    end else begin
      h5_hmem_acs_en <= gnt0 | gnt1;
      if (gnt0) begin
        h5_hmem_acs_type <= r0_type;
        h5_hmem_acs_sz   <= r0_sz;
        h5_hmem_acs_adrs <= r0_adrs;
        h5_hmem_wr_dt0   <= r0_wr_dt0;
        h5_hmem_wr_dt1   <= r0_wr_dt1;
      end else if (gnt1) begin
        h5_hmem_acs_type <= r1_type;
        h5_hmem_acs_sz   <= r1_sz;
        h5_hmem_acs_adrs <= r1_adrs;
        h5_hmem_wr_dt0   <= r1_wr_dt0;
        h5_hmem_wr_dt1   <= r1_wr_dt1;
      end
    end
  end

  // origin/read tracker, two deep to cover the heap's one-cycle read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_vld <= 1'b0;
      p1_org <= 1'b0;
      p2_vld <= 1'b0;
      p2_org <= 1'b0;
    end else begin
      p1_vld <= (gnt0 && !r0_type) || (gnt1 && !r1_type);
      p1_org <= gnt1;
      p2_vld <= p1_vld;
      p2_org <= p1_org;
    end
  end

  assign r0_gnt    = gnt0;
  assign r1_gnt    = gnt1;
  assign r0_rd_vld = p2_vld && !p2_org;
  assign r1_rd_vld = p2_vld && p2_org;
  assign rd_dt0    = h6_hmem_rd_dt0;
  assign rd_dt1    = h6_hmem_rd_dt1;
  assign locked    = (state == LOCK1);

endmodule

// File: tb/tb_sp1_hmem_arb.sv
// Bench for sp1_hmem_arb: heap model plus a read-return scoreboard.
`timescale 1ns/1ps

module tb_sp1_hmem_arb;
  localparam int DW = 32;
`ifdef SP1_HMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r0_req, r0_type, r0_sz, r0_gnt, r0_rd_vld;
  logic [DW-1:0] r0_adrs, r0_wr_dt0, r0_wr_dt1;
  logic r1_req, r1_type, r1_sz, r1_lock, r1_gnt, r1_rd_vld;
  logic [DW-1:0] r1_adrs, r1_wr_dt0, r1_wr_dt1;
  logic [DW-1:0] rd_dt0, rd_dt1;
  logic locked, h5_en, h5_type, h5_sz;
  logic [DW-1:0] h5_adrs, h5_wr0, h5_wr1;
  logic [DW-1:0] h6_rd0 = '0, h6_rd1 = '0;

  sp1_hmem_arb #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_type(r0_type), .r0_sz(r0_sz), .r0_adrs(r0_adrs),
    .r0_wr_dt0(r0_wr_dt0), .r0_wr_dt1(r0_wr_dt1), .r0_gnt(r0_gnt), .r0_rd_vld(r0_rd_vld),
    .r1_req(r1_req), .r1_type(r1_type), .r1_sz(r1_sz), .r1_adrs(r1_adrs),
    .r1_wr_dt0(r1_wr_dt0), .r1_wr_dt1(r1_wr_dt1), .r1_lock(r1_lock),
    .r1_gnt(r1_gnt), .r1_rd_vld(r1_rd_vld),
    .rd_dt0(rd_dt0), .rd_dt1(rd_dt1), .locked(locked),
    .h5_hmem_acs_en(h5_en), .h5_hmem_acs_type(h5_type), .h5_hmem_acs_sz(h5_sz),
    .h5_hmem_acs_adrs(h5_adrs), .h5_hmem_wr_dt0(h5_wr0), .h5_hmem_wr_dt1(h5_wr1),
    .h6_hmem_rd_dt0(h6_rd0), .h6_hmem_rd_dt1(h6_rd1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // heap model: one-cycle read latency, DOUBLE wraps within the 4 KB window
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (h5_en) begin
      if (h5_type) begin
        mem[h5_adrs[11:2]] <= h5_wr0;
        if (h5_sz) mem[h5_adrs[11:2] + 10'd1] <= h5_wr1;
      end else begin
        h6_rd0 <= mem[h5_adrs[11:2]];
        h6_rd1 <= mem[h5_adrs[11:2] + 10'd1];
      end
    end
  end

  typedef struct {
    bit          org;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          dbl;
    int          cyc;
  } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (r0_rd_vld && r1_rd_vld) begin
      check("both_rd_vld", 1, 0);
    end else if (r0_rd_vld || r1_rd_vld) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rd_vld", {r1_rd_vld, r0_rd_vld}, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rd_origin", r1_rd_vld, mon_e.org);
        check("rd_cycle", cyc, mon_e.cyc);
        check("rd_dt0", rd_dt0, mon_e.d0);
        if (mon_e.dbl) check("rd_dt1", rd_dt1, mon_e.d1);
      end
    end
  end

  // starts and ends on a falling edge; w = cycles spent waiting for grant
  task automatic r0_acc(input logic typ, input logic sz, input logic [31:0] a,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] e0, input logic [31:0] e1, output int w);
    r0_req = 1'b1; r0_type = typ; r0_sz = sz; r0_adrs = a;
    r0_wr_dt0 = w0; r0_wr_dt1 = w1;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (r0_gnt) begin
        if (!typ) sb_q.push_back('{1'b0, e0, e1, sz, cyc + 2});
        w = i;
        @(negedge clk);
        r0_req = 1'b0;
        return;
      end
      @(negedge clk);
    end
    w = 16;
    check("r0_gnt_timeout", 0, 1);
    r0_req = 1'b0;
  endtask

  task automatic pulse_rst();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int  w;
  bit  exp_r0;

  initial begin
    r0_req = 0; r0_type = 0; r0_sz = 0; r0_adrs = '0; r0_wr_dt0 = '0; r0_wr_dt1 = '0;
    r1_req = 0; r1_type = 0; r1_sz = 0; r1_adrs = '0; r1_wr_dt0 = '0; r1_wr_dt1 = '0;
    r1_lock = 0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem['h030 >> 2] = 32'h11111111; mem['h034 >> 2] = 32'h22222222;
    mem['h044 >> 2] = 32'h33333333; mem['h048 >> 2] = 32'h44444444;
    mem['h0a4 >> 2] = 32'h55555555; mem['h0a8 >> 2] = 32'h66666666;
    mem['h070 >> 2] = 32'h01010101; mem['h074 >> 2] = 32'h02020202;
    mem['h078 >> 2] = 32'h03030303; mem['h07c >> 2] = 32'h04040404;
    mem['hff8 >> 2] = 32'h77777777; mem['hffc >> 2] = 32'h88888888;

    // reset held five cycles; grants must stay low while rst is high
    repeat (4) @(negedge clk);
    r0_req = 1'b1; r1_req = 1'b1;
    #1;
    check("rst_r0_gnt", r0_gnt, 0);
    check("rst_r1_gnt", r1_gnt, 0);
    check("rst_h5_en", h5_en, 0);
    check("rst_locked", locked, 0);
    check("rst_h5_adrs", h5_adrs, 0);
    r0_req = 1'b0; r1_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // idle store then load by r0
    r0_acc(1'b1, 1'b0, 32'h010, 32'h01234567, 32'h0, 32'h0, 32'h0, w);
    check("t1_wr_gnt_wait", w, 0);
    #1;
    check("t1_h5_en", h5_en, 1);
    check("t1_h5_type", h5_type, 1);
    check("t1_h5_adrs", h5_adrs, 32'h010);
    check("t1_h5_wr0", h5_wr0, 32'h01234567);
    @(negedge clk);
    check("t1_h5_idle", h5_en, 0);
    r0_acc(1'b0, 1'b0, 32'h010, 32'h0, 32'h0, 32'h01234567, 32'h0, w);
    check("t1_rd_gnt_wait", w, 0);

    // DOUBLE at the top of the heap passes through unmodified
    r0_acc(1'b0, 1'b1, 32'hff8, 32'h0, 32'h0, 32'h77777777, 32'h88888888, w);
    #1;
    check("top_h5_adrs", h5_adrs, 32'hff8);
    check("top_h5_sz", h5_sz, 1);
    @(negedge clk);

    // contention: fixed priority keeps r0, round-robin alternates
    pulse_rst();
    for (int i = 0; i < 4; i++) begin
      r0_req = 1'b1; r0_type = 1'b0; r0_sz = 1'b1; r0_adrs = 32'h030;
      r1_req = 1'b1; r1_type = 1'b0; r1_sz = 1'b1; r1_adrs = 32'h044; r1_lock = 1'b0;
      #1;
      exp_r0 = RR ? (i % 2 == 0) : 1'b1;
      check("cont_r0_gnt", r0_gnt, exp_r0);
      check("cont_r1_gnt", r1_gnt, !exp_r0);
      if (r0_gnt) sb_q.push_back('{1'b0, 32'h11111111, 32'h22222222, 1'b1, cyc + 2});
      if (r1_gnt) sb_q.push_back('{1'b1, 32'h33333333, 32'h44444444, 1'b1, cyc + 2});
      @(negedge clk);
    end
    r0_req = 1'b0;
    #1;
    check("cont_r1_last_gnt", r1_gnt, 1);
    if (r1_gnt) sb_q.push_back('{1'b1, 32'h33333333, 32'h44444444, 1'b1, cyc + 2});
    @(negedge clk);
    r1_req = 1'b0;

    // lock span with r0 waiting
    pulse_rst();
    r1_req = 1'b1; r1_type = 1'b0; r1_sz = 1'b1; r1_adrs = 32'h0a4; r1_lock = 1'b1;
    #1;
    check("lk_a_locked", locked, 0);
    check("lk_a_r1_gnt", r1_gnt, 1);
    if (r1_gnt) sb_q.push_back('{1'b1, 32'h55555555, 32'h66666666, 1'b1, cyc + 2});
    @(negedge clk);
    r1_req = 1'b0;
    r0_req = 1'b1; r0_type = 1'b0; r0_sz = 1'b0; r0_adrs = 32'h070;
    #1;
    check("lk_b_locked", locked, 1);
    check("lk_b_r0_gnt", r0_gnt, 0);
    check("lk_b_r1_gnt", r1_gnt, 0);
    @(negedge clk);
    r1_req = 1'b1; r1_type = 1'b1; r1_sz = 1'b0; r1_wr_dt0 = 32'hdeadbeef; r1_lock = 1'b0;
    #1;
    check("lk_c_locked", locked, 1);
    check("lk_c_h5_idle", h5_en, 0);
    check("lk_c_r0_gnt", r0_gnt, 0);
    check("lk_c_r1_gnt", r1_gnt, 1);
    @(negedge clk);
    r1_req = 1'b0;
    #1;
    check("lk_d_locked", locked, 0);
    check("lk_d_r0_gnt", r0_gnt, 1);
    if (r0_gnt) sb_q.push_back('{1'b0, 32'h01010101, 32'h0, 1'b0, cyc + 2});
    @(negedge clk);
    r0_req = 1'b0;

    // reset lands one cycle after a locked r1 read grant
    repeat (3) @(negedge clk);
    r1_req = 1'b1; r1_type = 1'b0; r1_sz = 1'b1; r1_adrs = 32'h044; r1_lock = 1'b1;
    #1;
    check("rr_r1_gnt", r1_gnt, 1);
    @(negedge clk);
    r1_req = 1'b0;
    rst = 1'b1;
    r0_req = 1'b1; r0_type = 1'b0; r0_sz = 1'b0; r0_adrs = 32'h070;
    #1;
    check("rr_gnt_forced", r0_gnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rr_no_vld", r1_rd_vld, 0);
    check("rr_locked", locked, 0);
    check("rr_h5_en", h5_en, 0);
    check("rr_r0_gnt", r0_gnt, 1);
    if (r0_gnt) sb_q.push_back('{1'b0, 32'h01010101, 32'h0, 1'b0, cyc + 2});
    @(negedge clk);
    r0_req = 1'b0;

    // back-to-back reads
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      r0_acc(1'b0, 1'b0, 32'h070 + 4 * i, 32'h0, 32'h0, {4{8'(i + 1)}}, 32'h0, w);
      check("b2b_gnt_wait", w, 0);
    end

    repeat (5) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish by 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
